// File: rtl/perf_sample_ctrl_if.sv
// Trace stream carrying sampled (index, value, last) records
// from the performance sampler to its consumer.
interface perf_sample_ctrl_if #(
  parameter int XLEN = 64
);
  logic            smp_valid;
  logic            smp_ready;
  logic [2:0]      smp_idx;
  logic [XLEN-1:0] smp_value;
  logic            smp_last;

  modport master (
    output smp_valid, smp_idx, smp_value, smp_last,
    input  smp_ready
  );

  modport slave (
    input  smp_valid, smp_idx, smp_value, smp_last,
    output smp_ready
  );
endinterface

// File: rtl/perf_sample_ctrl.sv
// Periodic sampler for mhpmcounter3..8 sharing the counter CSR port
// with the CSR file, which always wins arbitration.
module perf_sample_ctrl #(
  parameter int          XLEN          = 64,
  parameter int          NUM_CNT       = 6,
  parameter logic [11:0] CNT_BASE_ADDR = 12'hB03,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          INTERVAL_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  csr_req_i,
  input  logic [11:0]           csr_addr_i,
  input  logic                  csr_we_i,
  input  logic [XLEN-1:0]       csr_wdata_i,
  output logic [XLEN-1:0]       csr_rdata_o,
  output logic [11:0]           pc_addr_o,
  output logic                  pc_we_o,
  output logic [XLEN-1:0]       pc_wdata_o,
  input  logic [XLEN-1:0]       pc_rdata_i,
  input  logic                  cfg_enable_i,
  input  logic [INTERVAL_W-1:0] cfg_interval_i,
  input  logic [NUM_CNT-1:0]    cfg_mask_i,
  perf_sample_ctrl_if.master    smp,
  output logic [15:0]           overrun_cnt_o,
  output logic                  busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SWEEP} state_t;

  typedef struct packed {
    logic [2:0]      idx;
    logic [XLEN-1:0] value;
    logic            last;
  } rec_t;

  state_t                state_q, state_n;
  logic [NUM_CNT-1:0]    mask_q, mask_n;
  logic [2:0]            idx_q, idx_n;
  logic [INTERVAL_W-1:0] timer_q;
  logic                  en_q;
  logic [15:0]           ovr_q;

  rec_t                  mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           cnt_q;

  logic       rise, tick, full, grant, pop;
  logic [2:0] first_idx, nxt_idx;
  logic       has_nxt;

  assign rise = cfg_enable_i & ~en_q;
  assign tick = cfg_enable_i & ~rise & (timer_q == '0);
  assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = smp.smp_valid & smp.smp_ready;

  // Descending scans so the lowest qualifying bit wins.
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    has_nxt   = 1'b0;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (cfg_mask_i[i]) first_idx = 3'(i);
      if (mask_q[i] && i > int'(idx_q)) begin
        nxt_idx = 3'(i);
        has_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    idx_n   = idx_q;
    grant   = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick && |cfg_mask_i) begin
          state_n = SWEEP;
          mask_n  = cfg_mask_i;
          idx_n   = first_idx;
        end
      end
      SWEEP: begin
        busy_o = 1'b1;
        grant  = ~csr_req_i & ~full;
        if (grant) begin
          if (has_nxt) idx_n = nxt_idx;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    csr_rdata_o = pc_rdata_i;
    pc_addr_o   = '0;
    pc_we_o     = 1'b0;
    pc_wdata_o  = '0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (state_q == SWEEP && !full) begin
      pc_addr_o = CNT_BASE_ADDR + {9'd0, idx_q};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      en_q    <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_n;
      mask_q  <= mask_n;
      idx_q   <= idx_n;
      en_q    <= cfg_enable_i;
      if (rise) timer_q <= cfg_interval_i;
      else if (cfg_enable_i) begin
        if (timer_q == '0) timer_q <= cfg_interval_i;
        else timer_q <= timer_q - 1'b1;
      end
      if (tick && state_q == SWEEP && ovr_q != 16'hFFFF)
        ovr_q <= ovr_q + 16'd1;
    end
  end

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (grant) begin
        mem[wptr_q] <= '{idx: idx_q, value: pc_rdata_i, last: ~has_nxt};
        wptr_q      <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(grant) - (AW+1)'(pop);
    end
  end

  assign smp.smp_valid = (cnt_q != '0);
  assign smp.smp_idx   = mem[rptr_q].idx;
  assign smp.smp_value = mem[rptr_q].value;
  assign smp.smp_last  = mem[rptr_q].last;
  assign overrun_cnt_o = ovr_q;

endmodule
